fms_patch_packer: RTL
=====================

// Module: fms_patch_packer
// PURPOSE
//  Upstream producer of the conv datapath's patch interface. Collects a raster pixel stream
//  (valid/ready) into a strip buffer FMS_PATCH_SIZE rows tall and IMG_WIDTH wide. Drains each
//  strip as flat FMS_PATCH_SIZE x FMS_PATCH_SIZE patches on infms_data/infms_data_vld, left to
//  right, one patch per enabled cycle, into the multiplication core.
// PARAMETERS
//  FMS_PATCH_SIZE   4   patch edge length in pixels
//  INFMS_DATA_WIDTH 8   signed pixel width
//  IMG_WIDTH        16  frame width in pixels; must be a multiple of FMS_PATCH_SIZE
//  IMG_HEIGHT       16  frame height in pixels; must be a multiple of FMS_PATCH_SIZE
//  Non-multiples raise an elaboration $error.
// PORTS
//  clk             in   1        clock; one clock domain
//  rst_n           in   1        asynchronous, active-low reset
//  clk_en          in   1        global enable; every state update is qualified by it
//  pix_data        in   IDW      signed raster pixel, row-major, frame top-left first
//  pix_vld         in   1        pix_data valid
//  pix_rdy         out  1        packer accepts pix_data this cycle
//  infms_data      out  IDW*P*P  flat patch, signed elements
//  infms_data_vld  out  1        infms_data holds a new patch
//  patch_col       out  CW       patch index in strip, CW=$clog2(IMG_WIDTH/P)
//  patch_row       out  RW       strip index in frame, RW=$clog2(IMG_HEIGHT/P)
//  patch_last      out  1        final patch of the frame
// BEHAVIOUR
//  Packing: element (r,c) of the patch sits at bits [((r*P+c)+1)*IDW-1 -: IDW].
//    (0,0) is at the LSBs, row-major.
//  Reset: state=FILL, all counters 0, infms_data=0, infms_data_vld=0,
//    patch_col/patch_row/patch_last=0. Buffer contents are don't-care.
//  pix_rdy = clk_en && (state==FILL). It is combinational and never high in DRAIN.
//  FILL: on pix_vld && pix_rdy, write buf[row_cnt][col_cnt]; col_cnt++.
//    At IMG_WIDTH-1, col_cnt wraps to 0 and row_cnt++.
//    Accepting pixel (P-1, IMG_WIDTH-1) -> DRAIN, with row_cnt and col_cnt cleared.
//  DRAIN: each clk_en cycle registers patch patch_cnt from the buffer and pulses
//    infms_data_vld=1. It sets patch_col=patch_cnt and patch_row=strip_cnt.
//    patch_last=1 iff patch_cnt==IMG_WIDTH/P-1 and strip_cnt==IMG_HEIGHT/P-1.
//  After the last patch of a strip: -> FILL, patch_cnt=0, strip_cnt++.
//    strip_cnt wraps to 0 after the last strip.
//  Latency: the last strip pixel is accepted at edge N. Patch 0 is visible after edge N+1.
//    Patches then follow back-to-back for IMG_WIDTH/P cycles (clk_en held high).
//  infms_data_vld drops to 0 on the first enabled FILL cycle after a drain.
//    infms_data holds its last value.
//  clk_en=0: every register holds, including infms_data_vld.
//    No pixel is accepted and no patch is skipped or duplicated.
//  Strips do not overlap: the fill of the next strip starts only after the drain completes.
//    Fill throughput is 1 pixel/cycle; drain throughput is 1 patch/cycle.
//  Reset mid-fill or mid-drain discards the partial strip. A full strip refill is required
//    before the next infms_data_vld.
//  Pixel values pass through unmodified; there is no padding. Zero-padding is owned by the
//    downstream core.
// STRUCTURE
//  Shared package conv_pkg holds:
//    - the pixel typedef (logic signed [INFMS_DATA_WIDTH-1:0]);
//    - the packer_state_e enum {FILL, DRAIN};
//    - a patch_bit_lsb(r,c) function, shared with the consumer for the packing.
//  Sub-module patch_strip_buffer:
//    - P x IMG_WIDTH storage, one write port (row, col, data);
//    - combinational patch read mux selected by patch_cnt, returning the flat packed vector.
//  Top level: FSM, counters, output registers.
// TESTING (P=4, IDW=8, IMG_WIDTH=16, IMG_HEIGHT=8; pixel(r,c)=(r*16+c) mod 256)
//  1 Ramp frame, pix_vld held high. Strip 0 patch 0:
//      bits[7:0]=0, [31:24]=3, [39:32]=16, [127:120]=51.
//    4 vld pulses with patch_col 0..3; patch 3 bits[7:0]=12.
//    First vld is 2 cycles after pixel(3,15) is accepted.
//  2 pix_vld randomly gapped (~50%) -> patches bit-identical to scenario 1.
//    pix_rdy=0 during every drain cycle; no pixel is lost.
//  3 clk_en=0 for 3 cycles after patch 1 of a strip:
//    vld/data/patch_col held at patch 1 through the stall.
//    The enabled-cycle sequence is still 0,1,2,3; no duplicate and no skip.
//  4 Strip 1, patch 3 -> patch_last=1, patch_row=1, data (4,12)=76 at bits[7:0].
//    patch_last=0 on all 7 earlier patches. Next frame starts with patch_row=0.
//  5 rst_n low after 20 pixels of strip 0 -> next edge: all outputs 0, pix_rdy=1.
//    No vld until 64 new pixels are accepted; first patch then equals scenario 1 patch 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared conv-datapath definitions: pixel type, packer FSM states and the
// flat-patch packing rule used by both producer and consumer.
package conv_pkg;

   localparam int PIXEL_WIDTH = 8;

   typedef logic signed [PIXEL_WIDTH-1:0] pixel_t;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } packer_state_e;

   // LSB position of patch element (r,c): row-major, (0,0) at bit 0.
   function automatic int patch_bit_lsb(input int r, input int c, input int p, input int idw);
      return (r * p + c) * idw;
   endfunction

endpackage

// File: rtl/patch_strip_buffer.sv
// Strip storage, FMS_PATCH_SIZE rows by IMG_WIDTH columns, with a single
// raster write port and a combinational flat-patch read mux.
module patch_strip_buffer
   import conv_pkg::*;
#(
   parameter int P         = 4,
   parameter int IDW       = 8,
   parameter int IMG_WIDTH = 16,
   localparam int NP = IMG_WIDTH / P,
   localparam int CW = (NP > 1) ? $clog2(NP) : 1,
   localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1,
   localparam int YW = (P > 1) ? $clog2(P) : 1,
   localparam int PW = IDW * P * P
) (
   input  logic          clk,
   input  logic          clk_en,
   input  logic          wr_en,
   input  logic [YW-1:0] wr_row,
   input  logic [XW-1:0] wr_col,
   input  logic [IDW-1:0] wr_data,
   input  logic [CW-1:0] patch_cnt,
   output logic [PW-1:0] patch_data
);

   localparam int DEPTH = P * IMG_WIDTH;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [IDW-1:0] mem [DEPTH];
   logic [AW-1:0]  wr_addr;

   assign wr_addr = AW'(int'(wr_row) * IMG_WIDTH + int'(wr_col));

   // Pixel write, one per accepted raster beat.
   // NOTE: storage has no reset; every location is rewritten before a drain reads it.
   always_ff @(posedge clk) begin
      if (clk_en && wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Gather the P x P window starting at column patch_cnt*P into one flat vector.
   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      patch_data = '0;
      for (int r = 0; r < P; r++) begin
         for (int c = 0; c < P; c++) begin
            patch_data[patch_bit_lsb(r, c, P, IDW) +: IDW] =
               mem[AW'(r * IMG_WIDTH + int'(patch_cnt) * P + c)];
         end
      end
   end

endmodule

// File: rtl/fms_patch_packer.sv
// Raster-to-patch packer: fills a strip buffer from a pixel stream, then
// drains it left to right as flat P x P patches, one per enabled cycle.
module fms_patch_packer
   import conv_pkg::*;
#(
   parameter int FMS_PATCH_SIZE   = 4,
   parameter int INFMS_DATA_WIDTH = 8,
   parameter int IMG_WIDTH        = 16,
   parameter int IMG_HEIGHT       = 16,
   localparam int NP = IMG_WIDTH / FMS_PATCH_SIZE,
   localparam int NS = IMG_HEIGHT / FMS_PATCH_SIZE,
   localparam int CW = (NP > 1) ? $clog2(NP) : 1,
   localparam int RW = (NS > 1) ? $clog2(NS) : 1,
   localparam int PW = INFMS_DATA_WIDTH * FMS_PATCH_SIZE * FMS_PATCH_SIZE
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clk_en,
   input  logic [INFMS_DATA_WIDTH-1:0] pix_data,
   input  logic                        pix_vld,
   output logic                        pix_rdy,
   output logic [PW-1:0]               infms_data,
   output logic                        infms_data_vld,
   output logic [CW-1:0]               patch_col,
   output logic [RW-1:0]               patch_row,
   output logic                        patch_last
);

   localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int YW = (FMS_PATCH_SIZE > 1) ? $clog2(FMS_PATCH_SIZE) : 1;

   if (IMG_WIDTH % FMS_PATCH_SIZE != 0) begin : g_bad_width
      $error("IMG_WIDTH must be a multiple of FMS_PATCH_SIZE");
   end
   if (IMG_HEIGHT % FMS_PATCH_SIZE != 0) begin : g_bad_height
      $error("IMG_HEIGHT must be a multiple of FMS_PATCH_SIZE");
   end

   packer_state_e state, state_nxt;
   logic [XW-1:0] col_cnt;
   logic [YW-1:0] row_cnt;
   logic [CW-1:0] patch_cnt;
   logic [RW-1:0] strip_cnt;
   logic [PW-1:0] buf_patch;
   logic          accept, col_end, row_end, patch_end, strip_end, drain_step;

   assign accept     = pix_vld && pix_rdy;
   assign col_end    = (col_cnt == XW'(IMG_WIDTH - 1));
   assign row_end    = (row_cnt == YW'(FMS_PATCH_SIZE - 1));
   assign patch_end  = (patch_cnt == CW'(NP - 1));
   assign strip_end  = (strip_cnt == RW'(NS - 1));
   assign drain_step = clk_en && (state == DRAIN);

   patch_strip_buffer #(
      .P         (FMS_PATCH_SIZE),
      .IDW       (INFMS_DATA_WIDTH),
      .IMG_WIDTH (IMG_WIDTH)
   ) u_buf (
      .clk        (clk),
      .clk_en     (clk_en),
      .wr_en      (accept),
      .wr_row     (row_cnt),
      .wr_col     (col_cnt),
      .wr_data    (pix_data),
      .patch_cnt  (patch_cnt),
      .patch_data (buf_patch)
   );

   // State register, advanced only on enabled cycles.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
      end else if (clk_en) begin
         state <= state_nxt;
      end
   end

   // Next state: last strip pixel starts the drain, last patch returns to fill.
   always_comb begin
      state_nxt = state;
      unique case (state)
         FILL:  if (accept && row_end && col_end) state_nxt = DRAIN;
         DRAIN: if (patch_end)                    state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   // Outputs decoded from state: ready only while filling.
   always_comb begin
      pix_rdy = clk_en && (state == FILL);
   end

   // Raster write position inside the strip.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (accept) begin
         if (col_end) begin
            col_cnt <= '0;
            row_cnt <= row_end ? '0 : row_cnt + YW'(1);
         end else begin
            col_cnt <= col_cnt + XW'(1);
         end
      end
   end

   // Patch index within the strip and strip index within the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         patch_cnt <= '0;
         strip_cnt <= '0;
      end else if (drain_step) begin
         if (patch_end) begin
            patch_cnt <= '0;
            strip_cnt <= strip_end ? '0 : strip_cnt + RW'(1);
         end else begin
            patch_cnt <= patch_cnt + CW'(1);
         end
      end
   end

   // Output registers: capture a patch per drain cycle, drop valid once filling resumes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         infms_data     <= '0;
         infms_data_vld <= 1'b0;
         patch_col      <= '0;
         patch_row      <= '0;
         patch_last     <= 1'b0;
      end else if (drain_step) begin
         infms_data     <= buf_patch;
         infms_data_vld <= 1'b1;
         patch_col      <= patch_cnt;
         patch_row      <= strip_cnt;
         patch_last     <= patch_end && strip_end;
      end else if (clk_en) begin
         infms_data_vld <= 1'b0;
      end
   end

endmodule
